// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide unit: owns HI/LO, runs mult/div with a fixed latency, services mthi/mtlo.
// Optional macro MDU_DIV0_HOLD_EN: divide-by-zero leaves HI/LO untouched instead of {A, all-ones}.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MADop,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Req,
    input  logic        D_HILO,
    output logic        Busy,
    output logic        Stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [3:0] MULT_N   = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N    = 4'(DIV_CYCLES);

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] p_hi, p_lo;
`ifdef MDU_DIV0_HOLD_EN
    logic        hold_q;
`endif

    logic        is_mul, is_div, div0;
    logic        a_neg, b_neg, sgn_mul;
    logic [31:0] a_mag, b_mag, b_den, q_mag, r_mag, quo, rem;
    logic [63:0] mul_a, mul_b, product, result;

    // Signed division runs on magnitudes; the quotient sign is the XOR of operand
    // signs and the remainder follows the dividend.
    always_comb begin
        is_mul  = (MADop == OP_MULT) || (MADop == OP_MULTU);
        is_div  = (MADop == OP_DIV) || (MADop == OP_DIVU);
        div0    = is_div && (B == 32'd0);
        sgn_mul = (MADop == OP_MULT);
        a_neg   = (MADop == OP_DIV) && A[31];
        b_neg   = (MADop == OP_DIV) && B[31];
        a_mag   = a_neg ? (32'd0 - A) : A;
        b_mag   = b_neg ? (32'd0 - B) : B;
        b_den   = (B == 32'd0) ? 32'd1 : b_mag;
        q_mag   = a_mag / b_den;
        r_mag   = a_mag % b_den;
        quo     = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem     = a_neg ? (32'd0 - r_mag) : r_mag;
        mul_a   = {{32{sgn_mul & A[31]}}, A};
        mul_b   = {{32{sgn_mul & B[31]}}, B};
        product = mul_a * mul_b;
        result  = 64'd0;
        if (is_mul)
            result = product;
        else if (div0)
            result = {A, 32'hFFFF_FFFF};
        else if (is_div)
            result = {rem, quo};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            p_hi  <= 32'd0;
            p_lo  <= 32'd0;
            HI    <= 32'd0;
            LO    <= 32'd0;
`ifdef MDU_DIV0_HOLD_EN
            hold_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (Start && !Req && (is_mul || is_div)) begin
                        {p_hi, p_lo} <= result;
                        cnt          <= is_mul ? MULT_N : DIV_N;
                        state        <= BUSY;
`ifdef MDU_DIV0_HOLD_EN
                        hold_q       <= div0;
`endif
                    end else if (!Req && MADop == OP_MTHI) begin
                        HI <= A;
                    end else if (!Req && MADop == OP_MTLO) begin
                        LO <= A;
                    end
                end
                BUSY: begin
                    // Requests arriving here are protocol violations and are dropped.
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= IDLE;
`ifdef MDU_DIV0_HOLD_EN
                        if (!hold_q) begin
                            HI <= p_hi;
                            LO <= p_lo;
                        end
`else
                        HI <= p_hi;
                        LO <= p_lo;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign Busy  = (state == BUSY);
    assign Stall = D_HILO & (Busy | Start);

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed corner steps plus randomized ops
// compared against an arithmetic reference model of HI/LO.
module tb_mdu_ctrl;
    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [2:0]  MADop;
    logic [31:0] A, B;
    logic        Req;
    logic        D_HILO;
    logic        Busy, Stall;
    logic [31:0] HI, LO;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .Start(Start), .MADop(MADop), .A(A), .B(B),
        .Req(Req), .D_HILO(D_HILO), .Busy(Busy), .Stall(Stall), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: what {HI,LO} become after a completed operation.
    function automatic logic [63:0] ref_calc(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic [31:0] hi, input logic [31:0] lo);
        longint sa, sb, q, r;
        logic [63:0] qv, rv;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if ((op == 3'd3 || op == 3'd4) && b == 32'd0) begin
`ifdef MDU_DIV0_HOLD_EN
            return {hi, lo};
`else
            return {a, 32'hFFFF_FFFF};
`endif
        end
        case (op)
            3'd1: return 64'(sa * sb);
            3'd2: return {32'd0, a} * {32'd0, b};
            3'd3: begin
                q = sa / sb;
                r = sa % sb;
                qv = 64'(q);
                rv = 64'(r);
                return {rv[31:0], qv[31:0]};
            end
            3'd4: return {a % b, a / b};
            default: return {hi, lo};
        endcase
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic dh, input string tag);
        logic [63:0] exp;
        int n, exp_n;
        exp   = ref_calc(op, a, b, model_hi, model_lo);
        exp_n = (op <= 3'd2) ? MULT_N : DIV_N;
        Start = 1'b1; MADop = op; A = a; B = b; D_HILO = dh;
        #1;
        check({tag, "_stall_start"}, {31'd0, Stall}, {31'd0, dh});
        tick();
        Start = 1'b0; MADop = 3'd0; A = $urandom; B = $urandom;
        #1;
        n = 0;
        while (Busy === 1'b1 && n < 20) begin
            check({tag, "_stall_busy"}, {31'd0, Stall}, {31'd0, dh});
            if (n == 0) check({tag, "_hi_held"}, HI, model_hi);
            n++;
            tick();
        end
        check({tag, "_busy_cycles"}, 32'(n), 32'(exp_n));
        {model_hi, model_lo} = exp;
        check({tag, "_hi"}, HI, model_hi);
        check({tag, "_lo"}, LO, model_lo);
        check({tag, "_stall_after"}, {31'd0, Stall}, 32'd0);
        D_HILO = 1'b0;
    endtask

    task automatic run_mt(input logic [2:0] op, input logic [31:0] a, input logic req,
                          input string tag);
        MADop = op; A = a; Req = req;
        #1;
        tick();
        MADop = 3'd0; Req = 1'b0;
        #1;
        if (!req) begin
            if (op == 3'd5) model_hi = a;
            else model_lo = a;
        end
        check({tag, "_hi"}, HI, model_hi);
        check({tag, "_lo"}, LO, model_lo);
        check({tag, "_busy"}, {31'd0, Busy}, 32'd0);
    endtask

    initial begin
        int n;
        logic [2:0]  op;
        logic [31:0] ra, rb;
        reset = 1'b0; Start = 1'b0; MADop = 3'd0; A = 32'd0; B = 32'd0;
        Req = 1'b0; D_HILO = 1'b0;

        // Reset
        tick(); tick();
        reset = 1'b1; D_HILO = 1'b1;
        #1;
        check("reset_hi", HI, 32'd0);
        check("reset_lo", LO, 32'd0);
        check("reset_busy", {31'd0, Busy}, 32'd0);
        check("reset_stall", {31'd0, Stall}, 32'd0);
        D_HILO = 1'b0;

        // Signed/unsigned multiply, Stall through a mult
        run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b1, "mult");
        check("mult_hi_const", HI, 32'hFFFF_FFFF);
        check("mult_lo_const", LO, 32'hFFFF_FFFA);
        run_op(3'd2, 32'hFFFF_FFFE, 32'd3, 1'b0, "multu");
        check("multu_hi_const", HI, 32'h0000_0002);

        // Divide
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, "div");
        check("div_lo_const", LO, 32'hFFFF_FFFD);
        check("div_hi_const", HI, 32'hFFFF_FFFF);
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
        check("div_ovf_lo_const", LO, 32'h8000_0000);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0, "divu");
        check("divu_lo_const", LO, 32'h7FFF_FFFC);
        check("divu_hi_const", HI, 32'h0000_0001);

        // mthi forced during BUSY is ignored
        Start = 1'b1; MADop = 3'd1; A = 32'd7; B = 32'd9;
        #1; tick();
        Start = 1'b0; MADop = 3'd0;
        #1; tick();
        MADop = 3'd5; A = 32'h1234;
        #1; tick();
        MADop = 3'd0;
        #1;
        n = 0;
        while (Busy === 1'b1 && n < 20) begin n++; tick(); end
        check("mthi_busy_wait", {31'd0, Busy}, 32'd0);
        model_hi = 32'd0; model_lo = 32'd63;
        check("mthi_busy_hi", HI, model_hi);
        check("mthi_busy_lo", LO, model_lo);

        // Flush suppression
        Start = 1'b1; MADop = 3'd1; A = 32'd5; B = 32'd5; Req = 1'b1;
        #1; tick();
        Start = 1'b0; MADop = 3'd0; Req = 1'b0;
        #1;
        check("req_start_busy", {31'd0, Busy}, 32'd0);
        tick();
        check("req_start_hi", HI, model_hi);
        check("req_start_lo", LO, model_lo);
        run_mt(3'd6, 32'hABCD, 1'b1, "mtlo_req");
        run_mt(3'd6, 32'hABCD, 1'b0, "mtlo");
        check("mtlo_const", LO, 32'h0000_ABCD);

        // Division by zero
        run_op(3'd3, 32'h55, 32'd0, 1'b0, "div0");
`ifdef MDU_DIV0_HOLD_EN
        check("div0_lo_const", LO, 32'h0000_ABCD);
`else
        check("div0_lo_const", LO, 32'hFFFF_FFFF);
        check("div0_hi_const", HI, 32'h0000_0055);
`endif
        run_op(3'd4, 32'h1234_5678, 32'd0, 1'b0, "divu0");
        run_mt(3'd5, 32'hCAFE_0001, 1'b0, "mthi");

        // Reset on busy cycle 3 of a div aborts it
        Start = 1'b1; MADop = 3'd3; A = 32'd100; B = 32'd7;
        #1; tick();
        Start = 1'b0; MADop = 3'd0;
        #1; tick(); tick();
        reset = 1'b0;
        #1; tick();
        reset = 1'b1;
        #1;
        model_hi = 32'd0; model_lo = 32'd0;
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_hi", HI, model_hi);
        check("rst_lo", LO, model_lo);
        repeat (12) tick();
        check("rst_nocommit_hi", HI, model_hi);
        check("rst_nocommit_lo", LO, model_lo);

        // Randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(1, 6));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
            if (op >= 3'd5) run_mt(op, ra, 1'($urandom_range(0, 1)), "rnd_mt");
            else run_op(op, ra, rb, 1'($urandom_range(0, 1)), "rnd_op");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
